c17_stim_resp: RTL and testbench

Stimulus generator and response checker for the registered c17 benchmark in the fault-emulation flow. It drives one pseudo-random 5-bit pattern per cycle into a golden and a fault-injected c17 copy, which share the same stimulus. It realigns their registered outputs for the 2-cycle DUT latency and compares them. It reports the mismatch count, the first failing pattern index and a MISR signature of the faulty copy's outputs.

---
 rtl/c17_bist_pkg.sv | 31 +++
 rtl/c17_misr.sv | 45 ++++
 rtl/c17_stim_resp.sv | 154 +++++++++++++++
 tb/tb_c17_stim_resp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 stimulus/response block: FSM states,
// LFSR polynomial, MISR polynomial, "no failure" index and DUT pipeline depth.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Fibonacci LFSR x^5 + x^3 + 1, shifting left: feedback = l[4] ^ l[2]
  localparam int unsigned LFSR_W    = 5;
  localparam logic [4:0]  LFSR_TAPS = 5'b10100;

  // MISR polynomial (CRC-16-CCITT form) and its width
  localparam int unsigned MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // FIRST_FAIL_IDX value meaning "no mismatch seen yet"
  localparam logic [15:0] IDX_NONE  = 16'hFFFF;

  // Cycles from STIM to registered c17 outputs
  localparam int unsigned DUT_LAT   = 2;

  // One LFSR step: shift left, feed the tap parity into bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// 16-bit multiple-input signature register compacting the 2-bit c17 response.
// Clear has priority over enable so a new run always starts from zero.
module c17_misr
  import c17_bist_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [1:0]        data_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                  input logic [1:0]        d);
    return {s[MISR_W-2:0], 1'b0}
         ^ (s[MISR_W-1] ? MISR_POLY : '0)
         ^ {{(MISR_W-2){1'b0}}, d};
  endfunction

  // Next signature: clear, fold in one response, or hold
  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = misr_step(sig_q, data_i);
    end
  end

  // Signature register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/c17_stim_resp.sv
// Stimulus generator / response checker for a golden and a fault-injected
// registered c17. Issues one LFSR pattern per RUN cycle, realigns the DUT
// responses through a valid/index pipe matching the DUT latency, counts
// mismatches, records the first failing index and compacts FAULT_Q in a MISR.
module c17_stim_resp
  import c17_bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 31,
  parameter logic [4:0]  LFSR_SEED  = 5'b00001
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic [4:0]  STIM,
  input  logic [1:0]  GOLD_Q,
  input  logic [1:0]  FAULT_Q,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] MISMATCH_CNT,
  output logic [15:0] FIRST_FAIL_IDX,
  output logic [15:0] SIG
);

  // An all-zero seed would lock the LFSR, so it is replaced
  localparam logic [4:0]  SEED_EFF  = (LFSR_SEED == 5'b00000) ? 5'b00001 : LFSR_SEED;
  localparam logic [15:0] LAST_IDX  = 16'(N_PATTERNS - 1);
  localparam logic [1:0]  DRAIN_END = 2'(DUT_LAT - 1);

  state_e      state_q, state_d;
  logic [4:0]  lfsr_q, lfsr_d;
  logic [15:0] pat_q, pat_d;
  logic [1:0]  drain_q, drain_d;
  logic [4:0]  stim_q, stim_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] mm_cnt_q, mm_cnt_d;
  logic [15:0] ffi_q, ffi_d;

  // Valid/index pipe, one stage per cycle of DUT latency
  logic        vld_p0_q, vld_p1_q;
  logic [15:0] idx_p0_q, idx_p1_q;

  logic        start_acc;
  logic        mismatch;

  assign start_acc = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch  = (GOLD_Q != FAULT_Q);

  // FSM next state, LFSR and pattern counter; registered outputs decoded from next state
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    pat_d   = pat_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_RUN;
          lfsr_d  = SEED_EFF;
          pat_d   = '0;
        end
      end
      ST_RUN: begin
        if (pat_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          lfsr_d = lfsr_next(lfsr_q);
          pat_d  = pat_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_END) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    stim_d = (state_d == ST_RUN) ? lfsr_d : 5'b00000;
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Mismatch counter (saturating) and first-failure capture on valid compare cycles
  always_comb begin
    mm_cnt_d = mm_cnt_q;
    ffi_d    = ffi_q;
    if (start_acc) begin
      mm_cnt_d = '0;
      ffi_d    = IDX_NONE;
    end else if (vld_p1_q && mismatch) begin
      if (mm_cnt_q != 16'hFFFF) begin
        mm_cnt_d = mm_cnt_q + 16'd1;
      end
      if (ffi_q == IDX_NONE) begin
        ffi_d = idx_p1_q;
      end
    end
  end

  // Control and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED_EFF;
      pat_q    <= '0;
      drain_q  <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mm_cnt_q <= '0;
      ffi_q    <= IDX_NONE;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      pat_q    <= pat_d;
      drain_q  <= drain_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mm_cnt_q <= mm_cnt_d;
      ffi_q    <= ffi_d;
      // p0: pattern presented this cycle; p1: its response is on the DUT outputs
      vld_p0_q <= start_acc ? 1'b0 : (state_q == ST_RUN);
      vld_p1_q <= start_acc ? 1'b0 : vld_p0_q;
    end
  end

  // Pattern index travelling alongside the valid bits (qualified by them)
  always_ff @(posedge CLK) begin
    idx_p0_q <= pat_q;
    idx_p1_q <= idx_p0_q;
  end

  c17_misr u_misr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (start_acc),
    .en_i   (vld_p1_q),
    .data_i (FAULT_Q),
    .sig_o  (SIG)
  );

  assign STIM           = stim_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign MISMATCH_CNT   = mm_cnt_q;
  assign FIRST_FAIL_IDX = ffi_q;

endmodule

// File: tb/tb_c17_stim_resp.sv
// Directed bench for c17_stim_resp: behavioural registered c17 models feed
// GOLD_Q/FAULT_Q; a second instance with N_PATTERNS=2 covers the short run.
module tb_c17_stim_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  stim;
  logic [1:0]  gold_q, fault_q;
  logic        busy, done;
  logic [15:0] cnt, ffi, sig;

  logic        start2 = 1'b0;
  logic [4:0]  stim2;
  logic [1:0]  gold2 = 2'b00;
  logic [1:0]  fault2 = 2'b00;
  logic        busy2, done2;
  logic [15:0] cnt2, ffi2, sig2;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;  // 0: faithful copy, 1: N22 stuck-at-1, 2: FAULT_Q tied 0

  logic [4:0] in_r = 5'b0;
  logic [1:0] gold_r = 2'b0;

  always #5 clk = ~clk;

  c17_stim_resp u_dut (
    .CLK(clk), .RST(rst), .START(start), .STIM(stim),
    .GOLD_Q(gold_q), .FAULT_Q(fault_q), .BUSY(busy), .DONE(done),
    .MISMATCH_CNT(cnt), .FIRST_FAIL_IDX(ffi), .SIG(sig)
  );

  c17_stim_resp #(.N_PATTERNS(2)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start2), .STIM(stim2),
    .GOLD_Q(gold2), .FAULT_Q(fault2), .BUSY(busy2), .DONE(done2),
    .MISMATCH_CNT(cnt2), .FIRST_FAIL_IDX(ffi2), .SIG(sig2)
  );

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [4:0] tb_lfsr(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  function automatic logic [15:0] tb_misr(input logic [15:0] s, input logic [1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
  endfunction

  // Registered c17: input register then output register (2-cycle latency)
  always @(posedge clk) begin
    in_r   <= stim;
    gold_r <= c17(in_r);
  end

  assign gold_q = gold_r;
  always_comb begin
    fault_q = gold_r;
    if (mode == 1)      fault_q = gold_r | 2'b01;
    else if (mode == 2) fault_q = 2'b00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected results of an n-pattern run from seed 1 under a fault mode
  task automatic model_run(input int m, input int n, output logic [15:0] ecnt,
                           output logic [15:0] effi, output logic [15:0] esig);
    logic [4:0] l;
    logic [1:0] g, f;
    l = 5'b00001; ecnt = 16'h0; effi = 16'hFFFF; esig = 16'h0;
    for (int k = 0; k < n; k++) begin
      g = c17(l);
      f = (m == 0) ? g : ((m == 1) ? (g | 2'b01) : 2'b00);
      if (g != f) begin
        ecnt = ecnt + 16'd1;
        if (effi == 16'hFFFF) effi = 16'(k);
      end
      esig = tb_misr(esig, f);
      l = tb_lfsr(l);
    end
  endtask

  // Pulse START, count BUSY cycles until DONE (bounded); optionally keep poking START
  task automatic run1(input bit poke, output int busy_cycles, output bit timed_out);
    start = 1'b1; tick(); start = 1'b0;
    busy_cycles = 0; timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin timed_out = 1'b0; break; end
      if (busy) busy_cycles++;
      if (poke) start = (busy_cycles < 20) && (i % 2 == 0);
      tick();
    end
    start = 1'b0;
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL run_timeout got no DONE within 200 cycles want DONE"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tick(); tick();
    n_tests++; if (stim !== 5'b0)      begin n_fail++; $display("FAIL reset_stim got %b want 00000", stim); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (cnt !== 16'h0)      begin n_fail++; $display("FAIL reset_cnt got %h want 0000", cnt); end
    n_tests++; if (ffi !== 16'hFFFF)   begin n_fail++; $display("FAIL reset_ffi got %h want ffff", ffi); end
    n_tests++; if (sig !== 16'h0)      begin n_fail++; $display("FAIL reset_sig got %h want 0000", sig); end
    rst = 1'b0; tick();
  endtask

  task automatic test_sequence();
    logic [4:0]  tbl [5];
    logic [4:0]  exp_l;
    logic [15:0] ecnt, effi, esig;
    int          nb;
    tbl[0] = 5'b00001; tbl[1] = 5'b00010; tbl[2] = 5'b00100; tbl[3] = 5'b01001; tbl[4] = 5'b10010;
    mode = 0;
    model_run(0, 31, ecnt, effi, esig);
    start = 1'b1; tick(); start = 1'b0;
    exp_l = 5'b00001; nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      if (busy) nb++;
      n_tests++;
      if (i < 5) begin
        if (stim !== tbl[i]) begin n_fail++; $display("FAIL seq_stim[%0d] got %b want %b", i, stim, tbl[i]); end
      end else if (i < 31) begin
        if (stim !== exp_l) begin n_fail++; $display("FAIL seq_stim[%0d] got %b want %b", i, stim, exp_l); end
      end else begin
        if (stim !== 5'b0) begin n_fail++; $display("FAIL drain_stim[%0d] got %b want 00000", i, stim); end
      end
      if (i == 2) begin
        n_tests++;
        if (gold_q !== 2'b00 || fault_q !== 2'b00) begin
          n_fail++; $display("FAIL resp_pat0 got gold %b fault %b want 00 00", gold_q, fault_q);
        end
      end
      exp_l = tb_lfsr(exp_l);
      tick();
    end
    n_tests++; if (nb != 33)          begin n_fail++; $display("FAIL seq_busy_len got %0d want 33", nb); end
    n_tests++; if (done !== 1'b1)     begin n_fail++; $display("FAIL seq_done got %b want 1", done); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL seq_busy_end got %b want 0", busy); end
    n_tests++; if (cnt !== 16'h0)     begin n_fail++; $display("FAIL seq_cnt got %h want 0000", cnt); end
    n_tests++; if (ffi !== 16'hFFFF)  begin n_fail++; $display("FAIL seq_ffi got %h want ffff", ffi); end
    n_tests++; if (sig !== esig)      begin n_fail++; $display("FAIL seq_sig got %h want %h", sig, esig); end
    n_tests++; if (stim !== 5'b0)     begin n_fail++; $display("FAIL done_stim got %b want 00000", stim); end
  endtask

  task automatic test_stuck_n22();
    logic [15:0] ecnt, effi, esig;
    int nb; bit to;
    mode = 1;
    model_run(1, 31, ecnt, effi, esig);
    run1(1'b0, nb, to);
    n_tests++; if (ffi !== 16'h0000)  begin n_fail++; $display("FAIL sa1_ffi got %h want 0000", ffi); end
    n_tests++; if (cnt !== ecnt)      begin n_fail++; $display("FAIL sa1_cnt got %h want %h", cnt, ecnt); end
    n_tests++; if (sig !== esig)      begin n_fail++; $display("FAIL sa1_sig got %h want %h", sig, esig); end
    n_tests++; if (nb != 33)          begin n_fail++; $display("FAIL sa1_busy_len got %0d want 33", nb); end
  endtask

  task automatic test_restart_from_done();
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL restart_done got %b want 0", done); end
    n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
    n_tests++; if (stim !== 5'b00001) begin n_fail++; $display("FAIL restart_stim got %b want 00001", stim); end
    n_tests++; if (cnt !== 16'h0)     begin n_fail++; $display("FAIL restart_cnt got %h want 0000", cnt); end
    n_tests++; if (ffi !== 16'hFFFF)  begin n_fail++; $display("FAIL restart_ffi got %h want ffff", ffi); end
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      tick();
    end
  endtask

  task automatic test_fault_zero();
    logic [15:0] ecnt, effi, esig;
    int nb; bit to;
    mode = 2;
    model_run(2, 31, ecnt, effi, esig);
    run1(1'b0, nb, to);
    n_tests++; if (sig !== 16'h0000)  begin n_fail++; $display("FAIL zero_sig got %h want 0000", sig); end
    n_tests++; if (cnt !== ecnt)      begin n_fail++; $display("FAIL zero_cnt got %h want %h", cnt, ecnt); end
    n_tests++; if (ffi !== effi)      begin n_fail++; $display("FAIL zero_ffi got %h want %h", ffi, effi); end
  endtask

  task automatic test_short_run();
    int nb; bit seen_done;
    start2 = 1'b1; tick(); start2 = 1'b0;
    nb = 0; seen_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      fault2 = (i == 2) ? 2'b01 : 2'b00;
      if (i == 0) begin
        n_tests++; if (stim2 !== 5'b00001) begin n_fail++; $display("FAIL n2_stim got %b want 00001", stim2); end
      end
      if (done2) begin seen_done = 1'b1; break; end
      if (busy2) nb++;
      tick();
    end
    fault2 = 2'b00;
    n_tests++; if (!seen_done)         begin n_fail++; $display("FAIL n2_timeout got no DONE want DONE"); end
    n_tests++; if (nb != 4)            begin n_fail++; $display("FAIL n2_busy_len got %0d want 4", nb); end
    n_tests++; if (sig2 !== 16'h0002)  begin n_fail++; $display("FAIL n2_sig got %h want 0002", sig2); end
    n_tests++; if (cnt2 !== 16'h0001)  begin n_fail++; $display("FAIL n2_cnt got %h want 0001", cnt2); end
    n_tests++; if (ffi2 !== 16'h0000)  begin n_fail++; $display("FAIL n2_ffi got %h want 0000", ffi2); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] ecnt, effi, esig;
    int nb; bit to;
    mode = 0;
    model_run(0, 31, ecnt, effi, esig);
    run1(1'b1, nb, to);
    n_tests++; if (nb != 33)          begin n_fail++; $display("FAIL poke_busy_len got %0d want 33", nb); end
    n_tests++; if (sig !== esig)      begin n_fail++; $display("FAIL poke_sig got %h want %h", sig, esig); end
    n_tests++; if (cnt !== 16'h0)     begin n_fail++; $display("FAIL poke_cnt got %h want 0000", cnt); end
  endtask

  task automatic test_rst_mid_run();
    logic [15:0] ecnt, effi, esig;
    int nb; bit to;
    mode = 1;  // make the aborted run dirty the result registers
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; #1;
    n_tests++; if (stim !== 5'b0)      begin n_fail++; $display("FAIL rst_stim got %b want 00000", stim); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_tests++; if (cnt !== 16'h0)      begin n_fail++; $display("FAIL rst_cnt got %h want 0000", cnt); end
    n_tests++; if (ffi !== 16'hFFFF)   begin n_fail++; $display("FAIL rst_ffi got %h want ffff", ffi); end
    n_tests++; if (sig !== 16'h0)      begin n_fail++; $display("FAIL rst_sig got %h want 0000", sig); end
    tick(); rst = 1'b0; tick(); tick();
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_no_autostart got %b want 0", busy); end
    mode = 0;
    model_run(0, 31, ecnt, effi, esig);
    run1(1'b0, nb, to);
    n_tests++; if (nb != 33)           begin n_fail++; $display("FAIL rerun_busy_len got %0d want 33", nb); end
    n_tests++; if (sig !== esig)       begin n_fail++; $display("FAIL rerun_sig got %h want %h", sig, esig); end
    n_tests++; if (cnt !== 16'h0)      begin n_fail++; $display("FAIL rerun_cnt got %h want 0000", cnt); end
    n_tests++; if (ffi !== 16'hFFFF)   begin n_fail++; $display("FAIL rerun_ffi got %h want ffff", ffi); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stuck_n22();
    test_restart_from_done();
    test_fault_zero();
    test_short_run();
    test_start_ignored();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
